// File: rtl/alu_panel_ctrl_if.sv
// alu_panel_ctrl_if: bundle between the panel controller and the external ALU.
// The controller (master) drives registered operands and opcode; the ALU
// (slave) returns its combinational result and flags.
interface alu_panel_ctrl_if #(
    parameter int N    = 8,
    parameter int OP_W = 6
);
    logic [N-1:0]    ALU_A;
    logic [N-1:0]    ALU_B;
    logic [OP_W-1:0] ALU_OP;
    logic [N-1:0]    ALU_RESULT;
    logic            ALU_ZERO;
    logic            ALU_CARRY;

    modport master (
        output ALU_A, ALU_B, ALU_OP,
        input  ALU_RESULT, ALU_ZERO, ALU_CARRY
    );

    modport slave (
        input  ALU_A, ALU_B, ALU_OP,
        output ALU_RESULT, ALU_ZERO, ALU_CARRY
    );
endinterface

// File: rtl/alu_panel_ctrl.sv
// alu_panel_ctrl: front-panel controller for an external combinational ALU.
// Three buttons load SW into operand A, operand B or the opcode; once all
// three have been loaded the ALU output is captured onto the LEDs two cycles
// after each load pulse. Optional button debounce is enabled by defining
// ALU_PANEL_DEBOUNCE_EN; otherwise the synchronized level is used directly.
// STATE_DBG exposes the FSM state (0 WAIT, 1 EXEC, 2 SHOW).
module alu_panel_ctrl #(
    parameter int N          = 8,
    parameter int OP_W       = 6,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                    CLK,
    input  logic                    BTN_RESET,
    input  logic [N-1:0]            SW,
    input  logic                    BTN_A,
    input  logic                    BTN_B,
    input  logic                    BTN_OP,
    alu_panel_ctrl_if.master        alu,
    output logic [N-1:0]            LED,
    output logic                    LED_ZERO,
    output logic                    LED_CARRY,
    output logic                    LED_READY,
    output logic [1:0]              STATE_DBG
);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_EXEC = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Button index: 0 = A, 1 = B, 2 = Op.
    logic [2:0] btn_raw;
    logic [2:0] btn_meta_q;
    logic [2:0] btn_sync_q;
    logic [2:0] lvl;
    logic [2:0] lvl_d1_q;
    logic [2:0] pulse;
    logic       any_pulse;

    logic [1:0] rst_sync_q;
    logic       rst;

    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [OP_W-1:0] op_q;
    logic [2:0]      loaded_q;
    logic [2:0]      loaded_d;

    state_t state_q;
    state_t state_d;
    logic   capture;

    assign btn_raw = {BTN_OP, BTN_B, BTN_A};

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge CLK or posedge BTN_RESET) begin
        if (BTN_RESET) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst = rst_sync_q[1];

    // Two-flop synchronizer on the raw buttons.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
        end
    end

`ifdef ALU_PANEL_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [2:0]    lvl_q;
    logic [CW-1:0] cnt_q [3];

    // Accept a new level only after DEB_CYCLES consecutive differing cycles.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_sync_q[i] != lvl_q[i]) begin
                    if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                        lvl_q[i] <= btn_sync_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = btn_sync_q;
`endif

    // Previous accepted level, for rising-edge detection.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            lvl_d1_q <= '0;
        end else begin
            lvl_d1_q <= lvl;
        end
    end

    // A load pulse lasts one cycle; the register it addresses updates on
    // the edge that ends that cycle.
    assign pulse     = lvl & ~lvl_d1_q;
    assign any_pulse = |pulse;
    assign loaded_d  = loaded_q | pulse;

    // Operand/opcode registers and sticky loaded flags.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            loaded_q <= '0;
        end else begin
            if (pulse[0]) a_q  <= SW;
            if (pulse[1]) b_q  <= SW;
            if (pulse[2]) op_q <= SW[OP_W-1:0];
            loaded_q <= loaded_d;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a pulse in EXEC keeps it there so the last capture
    // always sees the newest operands.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (any_pulse && (&loaded_d)) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = any_pulse ? ST_EXEC : ST_SHOW;
            end
            ST_SHOW: begin
                if (any_pulse) state_d = ST_EXEC;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // Capture ALU result and flags on every EXEC cycle.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            LED       <= '0;
            LED_ZERO  <= 1'b0;
            LED_CARRY <= 1'b0;
        end else if (capture) begin
            LED       <= alu.ALU_RESULT;
            LED_ZERO  <= alu.ALU_ZERO;
            LED_CARRY <= alu.ALU_CARRY;
        end
    end

    assign alu.ALU_A  = a_q;
    assign alu.ALU_B  = b_q;
    assign alu.ALU_OP = op_q;
    assign LED_READY  = (state_q == ST_SHOW);
    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_alu_panel_ctrl.sv
// tb_alu_panel_ctrl: directed bench for alu_panel_ctrl with an adding ALU.
// Timing offsets account for ALU_PANEL_DEBOUNCE_EN when it is defined.
module tb_alu_panel_ctrl;
    localparam int N   = 8;
    localparam int OPW = 6;
    localparam int DEB = 4;
`ifdef ALU_PANEL_DEBOUNCE_EN
    localparam int PD = DEB;
`else
    localparam int PD = 0;
`endif

    logic         CLK = 1'b0;
    logic         BTN_RESET;
    logic [N-1:0] SW;
    logic         BTN_A, BTN_B, BTN_OP;
    logic [N-1:0] LED;
    logic         LED_ZERO, LED_CARRY, LED_READY;
    logic [1:0]   STATE_DBG;

    int checks = 0;
    int errors = 0;

    alu_panel_ctrl_if #(.N(N), .OP_W(OPW)) alu ();

    // Reference ALU: plain add with carry-out and zero flag.
    assign {alu.ALU_CARRY, alu.ALU_RESULT} = {1'b0, alu.ALU_A} + {1'b0, alu.ALU_B};
    assign alu.ALU_ZERO = (alu.ALU_RESULT == '0);

    alu_panel_ctrl #(.N(N), .OP_W(OPW), .DEB_CYCLES(DEB)) dut (
        .CLK       (CLK),
        .BTN_RESET (BTN_RESET),
        .SW        (SW),
        .BTN_A     (BTN_A),
        .BTN_B     (BTN_B),
        .BTN_OP    (BTN_OP),
        .alu       (alu.master),
        .LED       (LED),
        .LED_ZERO  (LED_ZERO),
        .LED_CARRY (LED_CARRY),
        .LED_READY (LED_READY),
        .STATE_DBG (STATE_DBG)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive buttons {op,b,a} with a switch value, then wait until the load
    // edge has passed (pulse cycle t, register valid now at t+1).
    task automatic press(input logic [2:0] m, input logic [N-1:0] v);
        SW = v;
        {BTN_OP, BTN_B, BTN_A} = m;
        tick(PD + 3);
    endtask

    task automatic release_all();
        {BTN_OP, BTN_B, BTN_A} = 3'b000;
        tick(PD + 4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},     32'(alu.ALU_A), 32'h0);
        check({tag, "_b"},     32'(alu.ALU_B), 32'h0);
        check({tag, "_op"},    32'(alu.ALU_OP), 32'h0);
        check({tag, "_led"},   32'(LED), 32'h0);
        check({tag, "_zero"},  32'(LED_ZERO), 32'h0);
        check({tag, "_carry"}, 32'(LED_CARRY), 32'h0);
        check({tag, "_ready"}, 32'(LED_READY), 32'h0);
        check({tag, "_state"}, 32'(STATE_DBG), 32'h0);
    endtask

    initial begin
        BTN_RESET = 1'b1;
        SW = '0;
        {BTN_OP, BTN_B, BTN_A} = 3'b000;
        tick(3);
        check_all_zero("reset");
        BTN_RESET = 1'b0;
        tick(4);

        // Held A button: one load with the value present at the pulse.
        press(3'b001, 8'h05);
        check("hold_a_loaded", 32'(alu.ALU_A), 32'h05);
        SW = 8'h77;
        tick(7);
        check("hold_a_single", 32'(alu.ALU_A), 32'h05);
        check("hold_a_ready", 32'(LED_READY), 32'h0);
        release_all();

        // Full load sequence A=F0, B=20, Op from SW=E0 (upper bits dropped).
        press(3'b001, 8'hF0);
        release_all();
        press(3'b010, 8'h20);
        check("b_loaded", 32'(alu.ALU_B), 32'h20);
        check("b_wait_state", 32'(STATE_DBG), 32'h0);
        release_all();
        press(3'b100, 8'hE0);
        check("op_trunc", 32'(alu.ALU_OP), 32'h20);
        check("op_t1_ready", 32'(LED_READY), 32'h0);
        check("op_t1_exec", 32'(STATE_DBG), 32'h1);
        tick(1);
        check("op_t2_ready", 32'(LED_READY), 32'h1);
        check("op_t2_led", 32'(LED), 32'h10);
        check("op_t2_carry", 32'(LED_CARRY), 32'h1);
        check("op_t2_zero", 32'(LED_ZERO), 32'h0);
        release_all();

        // Three-cycle glitch on B while showing.
        SW = 8'h33;
        BTN_B = 1'b1;
        tick(3);
        BTN_B = 1'b0;
        tick(PD + 6);
`ifdef ALU_PANEL_DEBOUNCE_EN
        check("glitch_b", 32'(alu.ALU_B), 32'h20);
        check("glitch_led", 32'(LED), 32'h10);
        check("glitch_carry", 32'(LED_CARRY), 32'h1);
`else
        check("glitch_b", 32'(alu.ALU_B), 32'h33);
        check("glitch_led", 32'(LED), 32'h23);
        check("glitch_carry", 32'(LED_CARRY), 32'h1);
`endif
        check("glitch_ready", 32'(LED_READY), 32'h1);

        // A and B together from the same SW value.
        press(3'b011, 8'h80);
        check("ab_a", 32'(alu.ALU_A), 32'h80);
        check("ab_b", 32'(alu.ALU_B), 32'h80);
        check("ab_t1_ready", 32'(LED_READY), 32'h0);
        tick(1);
        check("ab_led", 32'(LED), 32'h00);
        check("ab_zero", 32'(LED_ZERO), 32'h1);
        check("ab_carry", 32'(LED_CARRY), 32'h1);
        check("ab_ready", 32'(LED_READY), 32'h1);
        release_all();

        // B pulse lands during EXEC started by A: one extra EXEC cycle.
        SW = 8'h03;
        BTN_A = 1'b1;
        tick(1);
        BTN_B = 1'b1;
        tick(PD + 2);
        check("ext_a", 32'(alu.ALU_A), 32'h03);
        check("ext_exec1", 32'(STATE_DBG), 32'h1);
        tick(1);
        check("ext_b", 32'(alu.ALU_B), 32'h03);
        check("ext_exec2", 32'(STATE_DBG), 32'h1);
        check("ext_ready_lo", 32'(LED_READY), 32'h0);
        tick(1);
        check("ext_ready_hi", 32'(LED_READY), 32'h1);
        check("ext_led", 32'(LED), 32'h06);
        check("ext_carry", 32'(LED_CARRY), 32'h0);
        release_all();

        // Reset in the middle of EXEC.
        press(3'b100, 8'h00);
        check("rst_pre_exec", 32'(STATE_DBG), 32'h1);
        #1;
        BTN_RESET = 1'b1;
        #1;
        check_all_zero("rst_exec");
        {BTN_OP, BTN_B, BTN_A} = 3'b000;
        tick(2);
        BTN_RESET = 1'b0;
        tick(4);
        press(3'b001, 8'h09);
        release_all();
        check("post_rst_a", 32'(alu.ALU_A), 32'h09);
        check("post_rst_ready", 32'(LED_READY), 32'h0);
        check("post_rst_state", 32'(STATE_DBG), 32'h0);
        check("post_rst_led", 32'(LED), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_panel_ctrl.md
ALU_PANEL_CTRL -- requirements
Module: alu_panel_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8: operand/result width in bits.
REQ-002 The block SHALL have parameter OP_W, default 6: opcode width in bits; legal range 1..N.
REQ-003 The block SHALL have parameter DEB_CYCLES, default 1000000: consecutive stable cycles required to accept a button level; legal range >= 1.
REQ-004 The block SHALL have port CLK  in  1  single system clock, all logic rising-edge.
REQ-005 The block SHALL have port BTN_RESET  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port SW  in  N  switch value loaded into A, B or Op.
REQ-007 The block SHALL have ports BTN_A, BTN_B, BTN_OP  in  1 each  raw, asynchronous load buttons, active-high.
REQ-008 The block SHALL have ports ALU_A, ALU_B  out  N each  registered operands driven to the external ALU.
REQ-009 The block SHALL have port ALU_OP  out  OP_W  registered opcode driven to the external ALU.
REQ-010 The block SHALL have ports ALU_RESULT  in  N, ALU_ZERO  in  1, ALU_CARRY  in  1  combinational ALU outputs.
REQ-011 The block SHALL have ports LED  out  N, LED_ZERO  out  1, LED_CARRY  out  1  captured result and flags.
REQ-012 The block SHALL have port LED_READY  out  1  high while captured result reflects the current A, B and Op.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each synchronized button SHALL produce a one-CLK load pulse on a rising edge of its accepted (debounced) level; holding a button SHALL NOT produce further pulses.
REQ-015 A load pulse SHALL update the matching register on the next edge: A <= SW, B <= SW, Op <= SW[OP_W-1:0]; SW bits above OP_W are ignored for Op.
REQ-016 Simultaneous pulses on several buttons SHALL load all addressed registers in the same cycle from the same SW value.
REQ-017 Per-register loaded flags SHALL set on load and clear only on reset.
REQ-018 The FSM SHALL have states WAIT, EXEC and SHOW.
REQ-019 WAIT: LED_READY=0; the FSM SHALL enter EXEC on the cycle after the load that makes all three loaded flags true.
REQ-020 EXEC: the FSM SHALL last exactly one cycle, capture ALU_RESULT/ALU_ZERO/ALU_CARRY into LED/LED_ZERO/LED_CARRY, and then enter SHOW.
REQ-021 SHOW: LED_READY=1 and LEDs SHALL hold; any load pulse SHALL drop LED_READY on the following cycle and enter EXEC, giving a fresh capture two cycles after the pulse.
REQ-022 Latency SHALL be fixed: pulse at cycle t, operand register updated at t+1, LEDs updated and LED_READY=1 at t+2.
REQ-023 A load pulse arriving during EXEC SHALL update its register and force one additional EXEC cycle, so the final capture always reflects the latest operands.
REQ-024 The block SHALL contain no arithmetic; it SHALL carry all result bits at width N without truncation.

Reset
REQ-025 BTN_RESET high SHALL asynchronously clear A, B, Op, LED, LED_ZERO, LED_CARRY, LED_READY, loaded flags, synchronizers, debounce counters and accepted levels to 0, and set the FSM to WAIT.
REQ-026 Reset asserted mid-EXEC SHALL abort capture; after release the block SHALL require all three loads again.
REQ-027 Release of BTN_RESET SHALL be synchronous to CLK.

Configuration
REQ-028 With macro ALU_PANEL_DEBOUNCE_EN defined, each button SHALL have a counter sized $clog2(DEB_CYCLES+1); the accepted level SHALL change only after the synchronized input differs from it for DEB_CYCLES consecutive cycles, and any reversion SHALL zero the counter.
REQ-029 Without ALU_PANEL_DEBOUNCE_EN, the accepted level SHALL equal the synchronizer output, DEB_CYCLES SHALL be unused, and no counters SHALL be built.

Verification (DEB_CYCLES=4, N=8, OP_W=6, ALU model = add)
REQ-030 Reset, then SW=0x05 with BTN_A held for 10 cycles SHALL give exactly one A load; LED_READY SHALL remain 0.
REQ-031 Load A=0xF0, B=0x20, Op=0x20 SHALL give LED=0x10, LED_CARRY=1 and LED_READY=1 two cycles after the Op pulse.
REQ-032 In SHOW, a 3-cycle glitch on BTN_B SHALL load nothing (debounce on); with the macro off, it SHALL load B and recapture.
REQ-033 Pressing BTN_A and BTN_B together with SW=0x80 SHALL give A=B=0x80 and LED=0x00, LED_ZERO=1, LED_CARRY=1.
REQ-034 BTN_RESET asserted during EXEC SHALL immediately return all outputs to 0; a following single load SHALL leave LED_READY=0.
